sram_operand_reader: RTL and testbench
======================================

# sram_operand_reader

Read-side sequencer for the two 8-entry operand SRAMs (A and B) that the keypad entry path fills. On a start pulse it walks the shared SRAM address from 0 upward, reads A[i] and B[i] together through the active-low async SRAM control pins, and hands each 16-bit FP operand pair to the MAC datapath over a valid/ready handshake. It sits between the SRAM pair and the MAC core. It owns the SRAM address and control lines whenever the top-level FSM is in RESULT.

## Interface
- DATA_W, 16, operand width (half-precision FP word as entered on keypad)
- ADDR_W, 4, SRAM address width
- DEPTH, 8, entries per SRAM (addresses 0..7)
- READ_WAIT, 2, cycles address/cs_n/oe_n are held before data is sampled (≥1)

- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- start  in  1  one-cycle request to begin a read pass; sampled only in IDLE
- len  in  ADDR_W  number of pairs to read, sampled with start; 0 → empty pass; >DEPTH clamped to DEPTH
- abort  in  1  synchronous cancel of a pass in progress
- sram_cs_n  out  1  chip select, both SRAMs, active-low
- sram_oe_n  out  1  output enable, both SRAMs, active-low
- sram_we_n  out  1  write enable, constant 1 (reader never writes)
- sram_addr  out  ADDR_W  shared address to both SRAMs
- sram_data_a  in  DATA_W  read data from SRAM A
- sram_data_b  in  DATA_W  read data from SRAM B
- op_a, op_b  out  DATA_W  registered operand pair to MAC
- op_valid  out  1  op_a/op_b/op_last valid
- op_last  out  1  current pair is the final pair of the pass
- op_ready  in  1  MAC accepts pair when op_valid & op_ready
- busy  out  1  pass in progress (state ≠ IDLE)
- done  out  1  one-cycle pulse after final pair accepted

## Operation
- States: IDLE, ACCESS, PRESENT.
- IDLE: cs_n=oe_n=1, op_valid=0. start & ~abort with len≠0 → ACCESS, addr=0, internal count=min(len,DEPTH). start with len=0 → done pulses next cycle, stays IDLE, no SRAM access.
- ACCESS: cs_n=oe_n=0, addr stable, wait counter counts READ_WAIT cycles. On the edge ending the last ACCESS cycle: op_a←sram_data_a, op_b←sram_data_b, op_last←(addr==count−1), op_valid←1, → PRESENT.
- PRESENT: cs_n=oe_n=1, op_* held stable until handshake. op_valid & op_ready: if ~op_last → addr+1, ACCESS; else → IDLE with done=1 for one cycle.
- op_a/op_b keep their last captured value after op_valid drops.
- abort in ACCESS or PRESENT: next cycle IDLE, op_valid=0, cs_n=oe_n=1, addr=0, no done. abort together with a handshake: the pair counts as taken by the MAC, still no done. abort & start in IDLE: start ignored.
- start while busy: ignored.
- Address never exceeds DEPTH−1; no wrap within a pass.

## Timing
- Reset values: sram_cs_n=1, sram_oe_n=1, sram_we_n=1, sram_addr=0, op_a=op_b=0, op_valid=0, op_last=0, busy=0, done=0; state IDLE, counters 0.
- start in cycle 0 → ACCESS cycles 1..READ_WAIT → op_valid high from cycle READ_WAIT+1.
- Handshake in cycle k (not last) → ACCESS from k+1, next op_valid at k+READ_WAIT+1. With op_ready held high, one pair per READ_WAIT+1 cycles.
- Handshake on last pair in cycle k → busy=0 and done=1 in cycle k+1. A start in cycle k+1 is accepted.
- rst mid-pass overrides everything: reset values next cycle, no done.

## Structure
- Shared package: DATA_W, ADDR_W, DEPTH, state encoding constants (IDLE/ACCESS/PRESENT), default READ_WAIT.
- One sub-module: sram_read_timer. It loads READ_WAIT, counts down, and flags the sample edge. The FSM, address counter and output registers stay in the top.

## Test plan
- SRAM model preloaded A[i]=0x3C00+i, B[i]=0x4000+i. start with len=8, op_ready=1 → 8 pairs (0x3C00,0x4000)…(0x3C07,0x4007) every 3 cycles, op_last only on the 8th, done 1 cycle later.
- len=3, op_ready low for 5 cycles on pair 1 → op_a=0x3C01 and op_b=0x4001 held stable throughout, sram_cs_n=1 during the stall, 3 pairs total.
- len=0 → done at cycle 1, sram_cs_n never low, op_valid never high.
- len=12 → clamped: exactly 8 pairs, sram_addr max 7.
- abort in ACCESS of address 4 → op_valid stays low, done never pulses, busy=0 next cycle. A new start with len=2 then returns addresses 0,1.
- rst asserted while op_valid=1 → all outputs at reset values next cycle. start during busy, and start with abort in IDLE, both ignored.

Source files
------------

// File: rtl/sram_operand_reader_pkg.sv
// rtl/sram_operand_reader_pkg.sv - shared widths, depth, state encoding and read-wait default
package sram_operand_reader_pkg;

    localparam int DATA_W            = 16;
    localparam int ADDR_W            = 4;
    localparam int DEPTH             = 8;
    localparam int READ_WAIT_DEFAULT = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        PRESENT = 2'd2
    } rd_state_e;

    // Requested pair count limited to the SRAM depth.
    function automatic logic [ADDR_W-1:0] clamp_len(input logic [ADDR_W-1:0] l);
        return (l > ADDR_W'(DEPTH)) ? ADDR_W'(DEPTH) : l;
    endfunction

endpackage

// File: rtl/sram_read_timer.sv
// rtl/sram_read_timer.sv - read-wait down-counter flagging the data sample edge
module sram_read_timer
    import sram_operand_reader_pkg::*;
#(
    parameter int READ_WAIT = READ_WAIT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic clear,
    input  logic run,
    output logic fire
);

    localparam int CNT_W = (READ_WAIT > 1) ? $clog2(READ_WAIT) : 1;

    logic [CNT_W-1:0] cnt;

    // Loaded on entry to an access; reaches zero in the last access cycle.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CNT_W'(READ_WAIT - 1);
        end else if (run && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign fire = run && (cnt == '0);

endmodule

// File: rtl/sram_operand_reader.sv
// rtl/sram_operand_reader.sv - sequences paired A/B SRAM reads into a valid/ready operand stream
module sram_operand_reader
    import sram_operand_reader_pkg::*;
#(
    parameter int READ_WAIT = READ_WAIT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] len,
    input  logic              abort,
    output logic              sram_cs_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic [ADDR_W-1:0] sram_addr,
    input  logic [DATA_W-1:0] sram_data_a,
    input  logic [DATA_W-1:0] sram_data_b,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,
    output logic              op_valid,
    output logic              op_last,
    input  logic              op_ready,
    output logic              busy,
    output logic              done
);

    rd_state_e         state, state_next;
    logic [ADDR_W-1:0] pass_cnt;

    logic pass_start;
    logic timer_load;
    logic timer_fire;
    logic capture;
    logic addr_inc;
    logic addr_clr;
    logic drop_valid;
    logic done_next;

    sram_read_timer #(
        .READ_WAIT (READ_WAIT)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .load  (timer_load),
        .clear (addr_clr),
        .run   (state == ACCESS),
        .fire  (timer_fire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        pass_start = 1'b0;
        timer_load = 1'b0;
        capture    = 1'b0;
        addr_inc   = 1'b0;
        addr_clr   = 1'b0;
        drop_valid = 1'b0;
        done_next  = 1'b0;
        unique case (state)
            IDLE: begin
                if (start && !abort) begin
                    if (len != '0) begin
                        pass_start = 1'b1;
                        timer_load = 1'b1;
                        state_next = ACCESS;
                    end else begin
                        done_next = 1'b1;
                    end
                end
            end
            ACCESS: begin
                if (abort) begin
                    addr_clr   = 1'b1;
                    state_next = IDLE;
                end else if (timer_fire) begin
                    capture    = 1'b1;
                    state_next = PRESENT;
                end
            end
            PRESENT: begin
                if (abort) begin
                    addr_clr   = 1'b1;
                    drop_valid = 1'b1;
                    state_next = IDLE;
                end else if (op_valid && op_ready) begin
                    drop_valid = 1'b1;
                    if (op_last) begin
                        addr_clr   = 1'b1;
                        done_next  = 1'b1;
                        state_next = IDLE;
                    end else begin
                        addr_inc   = 1'b1;
                        timer_load = 1'b1;
                        state_next = ACCESS;
                    end
                end
            end
            default: begin
                addr_clr   = 1'b1;
                drop_valid = 1'b1;
                state_next = IDLE;
            end
        endcase
    end

    // op_a/op_b are deliberately left holding the last pair once valid drops.
    always_ff @(posedge clk) begin
        if (rst) begin
            sram_addr <= '0;
            pass_cnt  <= '0;
            op_a      <= '0;
            op_b      <= '0;
            op_valid  <= 1'b0;
            op_last   <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= done_next;
            if (pass_start) begin
                pass_cnt  <= clamp_len(len);
                sram_addr <= '0;
            end else if (addr_clr) begin
                sram_addr <= '0;
            end else if (addr_inc) begin
                sram_addr <= sram_addr + ADDR_W'(1);
            end
            if (capture) begin
                op_a     <= sram_data_a;
                op_b     <= sram_data_b;
                op_valid <= 1'b1;
                op_last  <= (sram_addr == (pass_cnt - ADDR_W'(1)));
            end else if (drop_valid) begin
                op_valid <= 1'b0;
                op_last  <= 1'b0;
            end
        end
    end

    assign sram_cs_n = (state != ACCESS);
    assign sram_oe_n = (state != ACCESS);
    assign sram_we_n = 1'b1;
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_sram_operand_reader.sv
// tb/tb_sram_operand_reader.sv - directed and randomized bench for sram_operand_reader
module tb_sram_operand_reader;
    import sram_operand_reader_pkg::*;

    localparam int RW = READ_WAIT_DEFAULT;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] len;
    logic              abort;
    logic              sram_cs_n, sram_oe_n, sram_we_n;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_data_a, sram_data_b;
    logic [DATA_W-1:0] op_a, op_b;
    logic              op_valid, op_last, op_ready, busy, done;

    logic [DATA_W-1:0] mem_a [DEPTH];
    logic [DATA_W-1:0] mem_b [DEPTH];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign sram_data_a = (!sram_cs_n && !sram_oe_n && sram_addr < ADDR_W'(DEPTH))
                         ? mem_a[sram_addr[2:0]] : 16'hDEAD;
    assign sram_data_b = (!sram_cs_n && !sram_oe_n && sram_addr < ADDR_W'(DEPTH))
                         ? mem_b[sram_addr[2:0]] : 16'hBEEF;

    sram_operand_reader dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .len         (len),
        .abort       (abort),
        .sram_cs_n   (sram_cs_n),
        .sram_oe_n   (sram_oe_n),
        .sram_we_n   (sram_we_n),
        .sram_addr   (sram_addr),
        .sram_data_a (sram_data_a),
        .sram_data_b (sram_data_b),
        .op_a        (op_a),
        .op_b        (op_b),
        .op_valid    (op_valid),
        .op_last     (op_last),
        .op_ready    (op_ready),
        .busy        (busy),
        .done        (done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string pfx);
        chk({pfx, "_cs_n"},     sram_cs_n, 1);
        chk({pfx, "_oe_n"},     sram_oe_n, 1);
        chk({pfx, "_we_n"},     sram_we_n, 1);
        chk({pfx, "_addr"},     sram_addr, 0);
        chk({pfx, "_op_a"},     op_a, 0);
        chk({pfx, "_op_b"},     op_b, 0);
        chk({pfx, "_op_valid"}, op_valid, 0);
        chk({pfx, "_op_last"},  op_last, 0);
        chk({pfx, "_busy"},     busy, 0);
        chk({pfx, "_done"},     done, 0);
    endtask

    // One pass: expected pairs, timing and control pins follow from len and the handshake history.
    task automatic run_pass(input int len_i, input int ready_pct, input int stall_idx,
                            input int stall_len, input int abort_idx, input bit abort_present,
                            input bit noise_start);
        int n, idx, cyc, exp_cyc, stall_seen;
        bit fin, hs, do_abort;
        n = (len_i > DEPTH) ? DEPTH : len_i;
        idx = 0; stall_seen = 0; fin = 0;
        len = len_i[ADDR_W-1:0];
        start = 1'b1; abort = 1'b0; op_ready = 1'b0;
        step();
        start = 1'b0;
        cyc = 1;
        if (n == 0) begin
            chk("empty_done", done, 1);
            chk("empty_busy", busy, 0);
            chk("empty_cs_n", sram_cs_n, 1);
            chk("empty_valid", op_valid, 0);
            step();
            chk("empty_done_pulse", done, 0);
            chk("empty_cs_n2", sram_cs_n, 1);
            return;
        end
        exp_cyc = RW + 1;
        while (!fin && cyc < 300) begin
            chk("busy", busy, 1);
            chk("done_early", done, 0);
            chk("valid_timing", op_valid, (cyc >= exp_cyc));
            chk("cs_n", sram_cs_n, op_valid);
            chk("oe_n", sram_oe_n, op_valid);
            chk("we_n", sram_we_n, 1);
            chk("addr", sram_addr, idx);
            if (op_valid) begin
                chk("op_a", op_a, mem_a[idx]);
                chk("op_b", op_b, mem_b[idx]);
                chk("op_last", op_last, (idx == n - 1));
            end
            op_ready = ($urandom_range(99) < ready_pct);
            if (idx == stall_idx && op_valid && stall_seen < stall_len) begin
                op_ready = 1'b0;
                stall_seen++;
            end
            start    = noise_start ? 1'($urandom_range(1)) : 1'b0;
            len      = ADDR_W'($urandom_range(15));
            do_abort = (idx == abort_idx) && (op_valid == abort_present);
            abort    = do_abort;
            hs       = op_valid && op_ready;
            step();
            cyc++;
            abort = 1'b0;
            start = 1'b0;
            if (do_abort) begin
                chk("abort_busy", busy, 0);
                chk("abort_valid", op_valid, 0);
                chk("abort_cs_n", sram_cs_n, 1);
                chk("abort_addr", sram_addr, 0);
                chk("abort_done", done, 0);
                op_ready = 1'b0;
                step();
                chk("abort_done2", done, 0);
                chk("abort_busy2", busy, 0);
                return;
            end
            if (hs) begin
                if (idx == n - 1) fin = 1;
                else begin
                    idx++;
                    exp_cyc = cyc + RW;
                end
            end
        end
        chk("pass_timeout", fin, 1);
        chk("end_done", done, 1);
        chk("end_busy", busy, 0);
        chk("end_valid", op_valid, 0);
        chk("end_cs_n", sram_cs_n, 1);
        op_ready = 1'b0;
        step();
        chk("end_done_pulse", done, 0);
    endtask

    initial begin
        int w;
        rst = 1'b1; start = 1'b0; len = '0; abort = 1'b0; op_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            mem_a[i] = 16'h3C00 + 16'(i);
            mem_b[i] = 16'h4000 + 16'(i);
        end
        step(); step();
        chk_reset_vals("reset");
        rst = 1'b0;
        step();

        run_pass(8, 100, -1, 0, -1, 0, 0);
        run_pass(3, 100, 1, 5, -1, 0, 0);
        run_pass(0, 100, -1, 0, -1, 0, 0);
        run_pass(12, 100, -1, 0, -1, 0, 0);
        run_pass(8, 100, -1, 0, 4, 0, 0);
        run_pass(2, 100, -1, 0, -1, 0, 0);
        run_pass(6, 100, -1, 0, 2, 1, 0);
        run_pass(5, 60, -1, 0, -1, 0, 1);

        // start together with abort in IDLE is dropped
        start = 1'b1; abort = 1'b1; len = 4'd5;
        step();
        start = 1'b0; abort = 1'b0;
        chk("start_abort_busy", busy, 0);
        chk("start_abort_done", done, 0);
        step();
        chk("start_abort_busy2", busy, 0);
        chk("start_abort_cs_n", sram_cs_n, 1);

        // reset while a pair is presented
        len = 4'd4; start = 1'b1;
        step();
        start = 1'b0;
        w = 0;
        while (!op_valid && w < 20) begin
            step();
            w++;
        end
        chk("pre_rst_valid", op_valid, 1);
        rst = 1'b1;
        step();
        chk_reset_vals("mid_rst");
        rst = 1'b0;
        step();
        chk("post_rst_done", done, 0);

        for (int p = 0; p < 8; p++) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_a[i] = 16'($urandom);
                mem_b[i] = 16'($urandom);
            end
            run_pass($urandom_range(15), 30 + $urandom_range(70), -1, 0,
                     ($urandom_range(3) == 0) ? $urandom_range(7) : -1,
                     1'($urandom_range(1)), 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
